// File: rtl/k_and_s_pkg.sv
// Shared opcode and ALU encodings for the K-and-S control path.
// Opcode field is 5 bits wide so decoder values outside the ISA reach the control unit as unknown.
package k_and_s_pkg;

    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int unsigned MEM_WAIT_MAX = 15;

    function automatic logic is_branch_op(input decoded_instruction_type i);
        return (i == I_BRANCH) || (i == I_BZERO) || (i == I_BNZERO) || (i == I_BNEG) ||
               (i == I_BNNEG) || (i == I_BOV) || (i == I_BNOV);
    endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM sequencing fetch, decode, ALU, memory and branch steps for the K-and-S datapath.
// Outputs are a pure function of state (plus the held IR opcode/flags in the states that need them).
module multicycle_control_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned MEM_WAIT  = 1,
    parameter bit          BRANCH_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic                    instr_retired
);

    typedef enum logic [3:0] {
        StFetch, StFetchWait, StIrLoad, StDecode, StExecAlu,
        StMemWait, StLoadWb, StStoreWr, StBranchRes, StHalt
    } state_e;

    localparam logic [3:0] LP_WAIT = MEM_WAIT[3:0];

    state_e     r_state;
    state_e     w_state_d;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_d;
    logic       w_is_load;
    logic       w_cond;
    logic       w_unused;

    // Unsigned overflow has no branch opcode in this ISA.
    assign w_unused  = unsigned_overflow;
    assign w_is_load = (decoded_instruction == I_LOAD);

    always_comb begin
        w_cond = 1'b0;
        case (decoded_instruction)
            I_BRANCH: w_cond = 1'b1;
            I_BZERO:  w_cond = zero_op;
            I_BNZERO: w_cond = ~zero_op;
            I_BNEG:   w_cond = neg_op;
            I_BNNEG:  w_cond = ~neg_op;
            I_BOV:    w_cond = signed_overflow;
            I_BNOV:   w_cond = ~signed_overflow;
            default:  w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d        = r_state;
        w_cnt_d          = 4'd0;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_ADD;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        instr_retired    = 1'b0;

        unique case (r_state)
            StFetch: begin
                w_cnt_d   = LP_WAIT;
                w_state_d = (LP_WAIT != 4'd0) ? StFetchWait : StIrLoad;
            end
            StFetchWait: begin
                // Saturating decrement: the counter never wraps past zero.
                w_cnt_d = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
                if (r_cnt <= 4'd1) w_state_d = StIrLoad;
            end
            StIrLoad: begin
                ir_enable = 1'b1;
                pc_enable = 1'b1;
                w_state_d = StDecode;
            end
            StDecode: begin
                if (decoded_instruction == I_HALT) begin
                    w_state_d = StHalt;
                end else if (decoded_instruction == I_LOAD || decoded_instruction == I_STORE) begin
                    addr_sel = 1'b1;
                    w_cnt_d  = LP_WAIT;
                    if (LP_WAIT != 4'd0)  w_state_d = StMemWait;
                    else if (w_is_load)   w_state_d = StLoadWb;
                    else                  w_state_d = StStoreWr;
                end else if (decoded_instruction == I_MOVE || decoded_instruction == I_ADD ||
                             decoded_instruction == I_SUB  || decoded_instruction == I_AND ||
                             decoded_instruction == I_OR) begin
                    w_state_d = StExecAlu;
                end else if (BRANCH_EN && is_branch_op(decoded_instruction)) begin
                    w_state_d = StBranchRes;
                end else begin
                    instr_retired = 1'b1;
                    w_state_d     = StFetch;
                end
            end
            StMemWait: begin
                addr_sel = 1'b1;
                c_sel    = w_is_load;
                w_cnt_d  = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
                if (r_cnt <= 4'd1) w_state_d = w_is_load ? StLoadWb : StStoreWr;
            end
            StLoadWb: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                instr_retired    = 1'b1;
                w_state_d        = StFetch;
            end
            StStoreWr: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
                instr_retired    = 1'b1;
                w_state_d        = StFetch;
            end
            StExecAlu: begin
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
                instr_retired    = 1'b1;
                w_state_d        = StFetch;
                case (decoded_instruction)
                    I_SUB:   operation = OP_SUB;
                    I_AND:   operation = OP_AND;
                    I_OR:    operation = OP_OR;
                    I_MOVE: begin
                        // MOVE passes the operand through OR and must not disturb the flags.
                        operation        = OP_OR;
                        flags_reg_enable = 1'b0;
                    end
                    default: operation = OP_ADD;
                endcase
            end
            StBranchRes: begin
                branch        = w_cond;
                pc_enable     = w_cond;
                instr_retired = 1'b1;
                w_state_d     = StFetch;
            end
            StHalt: begin
                halt = 1'b1;
            end
            default: begin
                w_state_d = StFetch;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: five instances with different wait/branch settings,
// a hand-filled vector table, directed multi-cycle sequences and random opcode streams.
module tb_multicycle_control_unit;
    import k_and_s_pkg::*;

    localparam int NDUT = 5;
    localparam int unsigned MW_OF [NDUT] = '{0, 1, 3, 5, 2};
    localparam bit          BE_OF [NDUT] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    localparam logic [11:0] M_HALT  = 12'h800;
    localparam logic [11:0] M_RAMWE = 12'h400;
    localparam logic [11:0] M_FLAGS = 12'h200;
    localparam logic [11:0] M_CSEL  = 12'h100;
    localparam logic [11:0] M_ADDR  = 12'h080;
    localparam logic [11:0] M_WRE   = 12'h040;
    localparam logic [11:0] M_IR    = 12'h020;
    localparam logic [11:0] M_PC    = 12'h010;
    localparam logic [11:0] M_BR    = 12'h008;
    localparam logic [11:0] M_RET   = 12'h004;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic zero_op = 1'b0, neg_op = 1'b0, uovf = 1'b0, sovf = 1'b0;
    decoded_instruction_type instr [NDUT];
    logic [11:0] outs [NDUT];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc, ram_cnt, addr_cnt, br_cnt;
    int ir_log [$];
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic br, pce, ire, wre, asel, csel, fre, rwe, hlt, ret;
        logic [1:0] op;
        multicycle_control_unit #(.MEM_WAIT(MW_OF[g]), .BRANCH_EN(BE_OF[g])) u_dut (
            .clk                 (clk),
            .rst_n               (rst_n),
            .decoded_instruction (instr[g]),
            .zero_op             (zero_op),
            .neg_op              (neg_op),
            .unsigned_overflow   (uovf),
            .signed_overflow     (sovf),
            .branch              (br),
            .pc_enable           (pce),
            .ir_enable           (ire),
            .write_reg_enable    (wre),
            .addr_sel            (asel),
            .c_sel               (csel),
            .operation           (op),
            .flags_reg_enable    (fre),
            .ram_write_enable    (rwe),
            .halt                (hlt),
            .instr_retired       (ret)
        );
        assign outs[g] = {hlt, rwe, fre, csel, asel, wre, ire, pce, br, ret, op};
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: expected output word for every cycle of one instruction, starting at FETCH.
    task automatic build_exp(input int mw, input bit be, input decoded_instruction_type op,
                             input bit z, input bit n, input bit v);
        logic cond;
        logic [11:0] alu;
        exp_q.delete();
        exp_q.push_back(12'h000);
        repeat (mw) exp_q.push_back(12'h000);
        exp_q.push_back(M_IR | M_PC);
        case (op)
            I_HALT: begin
                exp_q.push_back(12'h000);
                repeat (3) exp_q.push_back(M_HALT);
            end
            I_LOAD: begin
                exp_q.push_back(M_ADDR);
                repeat (mw) exp_q.push_back(M_ADDR | M_CSEL);
                exp_q.push_back(M_ADDR | M_CSEL | M_WRE | M_RET);
            end
            I_STORE: begin
                exp_q.push_back(M_ADDR);
                repeat (mw) exp_q.push_back(M_ADDR);
                exp_q.push_back(M_ADDR | M_RAMWE | M_RET);
            end
            I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
                alu = M_WRE | M_RET | M_FLAGS;
                if (op == I_SUB) alu = alu | 12'd1;
                if (op == I_AND) alu = alu | 12'd2;
                if (op == I_OR)  alu = alu | 12'd3;
                if (op == I_MOVE) alu = M_WRE | M_RET | 12'd3;
                exp_q.push_back(12'h000);
                exp_q.push_back(alu);
            end
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                if (!be) begin
                    exp_q.push_back(M_RET);
                end else begin
                    cond = (op == I_BRANCH) || (op == I_BZERO && z) || (op == I_BNZERO && !z) ||
                           (op == I_BNEG && n) || (op == I_BNNEG && !n) ||
                           (op == I_BOV && v) || (op == I_BNOV && !v);
                    exp_q.push_back(12'h000);
                    exp_q.push_back(cond ? (M_BR | M_PC | M_RET) : M_RET);
                end
            end
            default: exp_q.push_back(M_RET);
        endcase
    endtask

    task automatic run_instr(input int k, input decoded_instruction_type op, input bit z,
                             input bit n, input bit v, output int ret_idx,
                             output logic [11:0] ret_word);
        instr[k] = op;
        zero_op  = z;
        neg_op   = n;
        sovf     = v;
        uovf     = 1'($urandom);
        build_exp(int'(MW_OF[k]), BE_OF[k], op, z, n, v);
        ret_idx  = 0;
        ret_word = 12'h000;
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            cyc++;
            check($sformatf("seq_d%0d_op%0d_c%0d", k, int'(op), i), outs[k], exp_q[i]);
            if ((outs[k] & M_RET) != 0 && ret_idx == 0) begin
                ret_idx  = i + 1;
                ret_word = outs[k];
            end
            if ((outs[k] & M_IR) != 0)    ir_log.push_back(cyc);
            if ((outs[k] & M_RAMWE) != 0) ram_cnt++;
            if ((outs[k] & M_ADDR) != 0)  addr_cnt++;
            if ((outs[k] & M_BR) != 0)    br_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic clear_logs();
        cyc = 0; ram_cnt = 0; addr_cnt = 0; br_cnt = 0;
        ir_log.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) check($sformatf("reset_d%0d", k), outs[k], 12'h000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    typedef struct {
        decoded_instruction_type op;
        bit z, n, v;
        int ret;
        logic [11:0] word;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [$];
        int ri;
        logic [11:0] rw;
        int r;
        for (int k = 0; k < NDUT; k++) instr[k] = I_NOP;

        // Table for the MEM_WAIT=1 instance: retire cycle (1 = FETCH) and retire-cycle outputs.
        tbl.push_back('{I_NOP,    0, 0, 0, 4, 12'h004});
        tbl.push_back('{I_ADD,    0, 0, 0, 5, 12'h244});
        tbl.push_back('{I_SUB,    0, 0, 0, 5, 12'h245});
        tbl.push_back('{I_AND,    0, 0, 0, 5, 12'h246});
        tbl.push_back('{I_OR,     0, 0, 0, 5, 12'h247});
        tbl.push_back('{I_MOVE,   0, 0, 0, 5, 12'h047});
        tbl.push_back('{I_LOAD,   0, 0, 0, 6, 12'h1C4});
        tbl.push_back('{I_STORE,  0, 0, 0, 6, 12'h484});
        tbl.push_back('{I_BZERO,  1, 0, 0, 5, 12'h01C});
        tbl.push_back('{I_BZERO,  0, 0, 0, 5, 12'h004});
        tbl.push_back('{I_BNZERO, 0, 1, 1, 5, 12'h01C});
        tbl.push_back('{I_BNEG,   0, 1, 0, 5, 12'h01C});
        tbl.push_back('{I_BNNEG,  0, 1, 0, 5, 12'h004});
        tbl.push_back('{I_BOV,    0, 0, 1, 5, 12'h01C});
        tbl.push_back('{I_BNOV,   1, 1, 1, 5, 12'h004});
        tbl.push_back('{I_BRANCH, 0, 0, 0, 5, 12'h01C});
        tbl.push_back('{decoded_instruction_type'(5'd20), 0, 0, 0, 4, 12'h004});

        do_reset();
        foreach (tbl[i]) begin
            run_instr(1, tbl[i].op, tbl[i].z, tbl[i].n, tbl[i].v, ri, rw);
            check_int($sformatf("tbl%0d_retire_cycle", i), ri, tbl[i].ret);
            check($sformatf("tbl%0d_retire_word", i), rw, tbl[i].word);
        end

        // MEM_WAIT=0 program LOAD, STORE, HALT.
        do_reset();
        run_instr(0, I_LOAD, 0, 0, 0, ri, rw);
        run_instr(0, I_STORE, 0, 0, 0, ri, rw);
        run_instr(0, I_HALT, 0, 0, 0, ri, rw);
        check_int("prog_ir_count", ir_log.size(), 3);
        check_int("prog_ir0", (ir_log.size() > 0) ? ir_log[0] : -1, 2);
        check_int("prog_ir1", (ir_log.size() > 1) ? ir_log[1] : -1, 6);
        check_int("prog_ir2", (ir_log.size() > 2) ? ir_log[2] : -1, 10);
        check_int("prog_ram_we_cycles", ram_cnt, 1);
        repeat (5) begin
            #1 check("halt_hold", outs[0], M_HALT);
            @(negedge clk);
        end

        // MEM_WAIT=3 load: write-back cycle and address hold.
        do_reset();
        run_instr(2, I_LOAD, 0, 0, 0, ri, rw);
        check_int("mw3_load_wb_cycle", ri, 10);
        check_int("mw3_addr_sel_cycles", addr_cnt, 5);

        // BRANCH_EN=0 instance: branch retired as NOP.
        do_reset();
        run_instr(4, I_BRANCH, 1, 1, 1, ri, rw);
        check_int("nobr_retire_cycle", ri, 5);
        check_int("nobr_branch_cycles", br_cnt, 0);

        // Reset pulse in the middle of a MEM_WAIT=5 store.
        do_reset();
        instr[3] = I_STORE;
        repeat (8) @(negedge clk);
        #1 check("mid_wait_addr", outs[3], M_ADDR);
        #2 rst_n = 1'b0;
        #1 check("mid_wait_reset", outs[3], 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        run_instr(3, I_NOP, 0, 0, 0, ri, rw);
        run_instr(3, I_NOP, 0, 0, 0, ri, rw);
        check_int("restart_ir_first", (ir_log.size() > 0) ? ir_log[0] : -1, 7);
        check_int("restart_ram_we", ram_cnt, 0);

        // Random opcode streams on every instance.
        for (int k = 0; k < NDUT; k++) begin
            do_reset();
            repeat (25) begin
                r = int'($urandom_range(0, 20));
                if (r == 15) r = 0;
                run_instr(k, decoded_instruction_type'(5'(r)), 1'($urandom), 1'($urandom),
                          1'($urandom), ri, rw);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
